top_uart_golden_top: RTL and testbench

TOP_UART_GOLDEN_TOP -- requirements
Module: top_uart_golden_top

---
 rtl/uart_pkg.sv | 50 +++++
 rtl/top_uart_golden_top_baud_prescaler.sv | 65 ++++++
 rtl/top_uart_golden_top.sv | 168 ++++++++++++++++
 tb/tb_top_uart_golden_top.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and helpers for the UART golden top.
//   baud_sel_t   - SW[2:1] baud-select encodings
//   tx/rx state  - FSM state encodings
//   SEG_*        - active-low seven-segment codes, order {g,f,e,d,c,b,a}
//   baud_divisor - rounded CLK_FREQ_HZ / baud, for constant elaboration only
//   baud_hex     - six-digit baud display {HEX5..HEX0}, leading zeros blanked
package uart_pkg;

    typedef enum logic [1:0] {
        BAUD_4800   = 2'b00,
        BAUD_9600   = 2'b01,
        BAUD_19200  = 2'b10,
        BAUD_115200 = 2'b11
    } baud_sel_t;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic int unsigned baud_rate(baud_sel_t sel);
        case (sel)
            BAUD_4800:   return 4800;
            BAUD_9600:   return 9600;
            BAUD_19200:  return 19200;
            default:     return 115200;
        endcase
    endfunction

    function automatic int unsigned baud_divisor(baud_sel_t sel, int unsigned clk_hz);
        return (clk_hz + baud_rate(sel) / 2) / baud_rate(sel);
    endfunction

    function automatic logic [41:0] baud_hex(baud_sel_t sel);
        case (sel)
            BAUD_4800:   return {SEG_BLANK, SEG_BLANK, SEG_DIGIT[4], SEG_DIGIT[8],
                                 SEG_DIGIT[0], SEG_DIGIT[0]};
            BAUD_9600:   return {SEG_BLANK, SEG_BLANK, SEG_DIGIT[9], SEG_DIGIT[6],
                                 SEG_DIGIT[0], SEG_DIGIT[0]};
            BAUD_19200:  return {SEG_BLANK, SEG_DIGIT[1], SEG_DIGIT[9], SEG_DIGIT[2],
                                 SEG_DIGIT[0], SEG_DIGIT[0]};
            default:     return {SEG_DIGIT[1], SEG_DIGIT[1], SEG_DIGIT[5], SEG_DIGIT[2],
                                 SEG_DIGIT[0], SEG_DIGIT[0]};
        endcase
    endfunction

endpackage

// File: rtl/top_uart_golden_top_baud_prescaler.sv
// baud_prescaler: divides clk down to a one-cycle tick per baud period.
//   clk, rst_n - clock, asynchronous active-low reset
//   sel        - baud select (SW[2:1] encoding)
//   restart    - reload the counter (frame start)
//   tick       - one-cycle pulse every divisor cycles
// HALF_PHASE=1 makes the first tick after a restart arrive half a divisor
// later (mid-bit sampling for the receiver).
module baud_prescaler
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter bit          HALF_PHASE  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sel,
    input  logic       restart,
    output logic       tick
);

    localparam int unsigned DIV_4800   = baud_divisor(BAUD_4800,   CLK_FREQ_HZ);
    localparam int unsigned DIV_9600   = baud_divisor(BAUD_9600,   CLK_FREQ_HZ);
    localparam int unsigned DIV_19200  = baud_divisor(BAUD_19200,  CLK_FREQ_HZ);
    localparam int unsigned DIV_115200 = baud_divisor(BAUD_115200, CLK_FREQ_HZ);
    localparam int unsigned CW         = $clog2(DIV_4800);

    logic [31:0]   div;
    logic [CW-1:0] div_m1;
    logic [CW-1:0] load_val;
    logic [CW-1:0] cnt;
    logic [1:0]    sel_q;
    logic          sel_change;

    always_comb begin
        div = DIV_4800;
        case (baud_sel_t'(sel))
            BAUD_4800:   div = DIV_4800;
            BAUD_9600:   div = DIV_9600;
            BAUD_19200:  div = DIV_19200;
            BAUD_115200: div = DIV_115200;
            default:     div = DIV_4800;
        endcase
    end

    assign div_m1     = CW'(div - 32'd1);
    assign load_val   = HALF_PHASE ? CW'(div - div / 32'd2) : '0;
    assign sel_change = (sel != sel_q);
    assign tick       = (cnt == div_m1) && !restart && !sel_change;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            sel_q <= 2'b00;
        end else begin
            sel_q <= sel;
            if (restart || sel_change)
                cnt <= load_val;
            else if (cnt == div_m1)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/top_uart_golden_top.sv
// top_uart_golden_top: 8N1 UART transmitter/receiver with switch control.
//   CLOCK_50 - system clock          RESET_N - async active-low reset
//   KEY[0]   - send request (active-high, rising edge)
//   SW       - [0] enable, [2:1] baud, [3] RX en, [4] TX en, [9:5] TX data
//   LEDR     - [7:0] last RX byte, [8] TX busy, [9] RX frame error
//   HEX0..5  - selected baud rate in decimal (active-low)
//   GPIO_0   - [0] TX line out, [1] RX line in, others high-Z
module top_uart_golden_top
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    inout  wire  [35:0] GPIO_0
);

    logic [1:0] rst_pipe;
    logic       rst_n;
    logic [1:0] key_sync, rx_sync;
    logic       key_q, rx_q, send_req, rx_fall, rx_bit;
    logic       tx_active, tx_start, tx_tick, tx_line, tx_busy;
    logic       rx_armed, rx_go, rx_tick, rx_err;
    logic [7:0] tx_shift, rx_shift, rx_byte;
    logic [2:0] tx_cnt, rx_cnt;
    logic [41:0] hex_q;
    tx_state_t  tx_state;
    rx_state_t  rx_state;
    logic       unused_inputs;

    // Asserts asynchronously, releases two clocks after RESET_N rises.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) rst_pipe <= '0;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            key_sync <= 2'b00;
            key_q    <= 1'b0;
            rx_sync  <= 2'b11;
            rx_q     <= 1'b1;
        end else begin
            key_sync <= {key_sync[0], KEY[0]};
            key_q    <= key_sync[1];
            rx_sync  <= {rx_sync[0], GPIO_0[1]};
            rx_q     <= rx_sync[1];
        end
    end

    assign send_req  = key_sync[1] & ~key_q;
    assign rx_fall   = rx_q & ~rx_sync[1];
    assign rx_bit    = rx_sync[1];
    assign tx_active = SW[0] & SW[4];
    assign tx_start  = send_req & tx_active & (tx_state == TX_IDLE);
    assign rx_armed  = SW[0] & SW[3];
    assign rx_go     = rx_armed & rx_fall & (rx_state == RX_IDLE);

    baud_prescaler #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .HALF_PHASE(1'b0)) u_tx_baud (
        .clk(CLOCK_50), .rst_n(rst_n), .sel(SW[2:1]), .restart(tx_start), .tick(tx_tick)
    );

    baud_prescaler #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .HALF_PHASE(1'b1)) u_rx_baud (
        .clk(CLOCK_50), .rst_n(rst_n), .sel(SW[2:1]), .restart(rx_go), .tick(rx_tick)
    );

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_line  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_shift <= '0;
            tx_cnt   <= '0;
        end else if (tx_state != TX_IDLE && !tx_active) begin
            tx_state <= TX_IDLE;
            tx_line  <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: if (tx_start) begin
                    tx_shift <= {3'b000, SW[9:5]};
                    tx_line  <= 1'b0;
                    tx_busy  <= 1'b1;
                    tx_state <= TX_START;
                end
                TX_START: if (tx_tick) begin
                    tx_line  <= tx_shift[0];
                    tx_shift <= {1'b0, tx_shift[7:1]};
                    tx_cnt   <= '0;
                    tx_state <= TX_DATA;
                end
                TX_DATA: if (tx_tick) begin
                    if (tx_cnt == 3'd7) begin
                        tx_line  <= 1'b1;
                        tx_state <= TX_STOP;
                    end else begin
                        tx_line  <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_cnt   <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: if (tx_tick) begin
                    tx_busy  <= 1'b0;
                    tx_state <= TX_IDLE;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_shift <= '0;
            rx_cnt   <= '0;
            rx_byte  <= '0;
            rx_err   <= 1'b0;
        end else if (!rx_armed) begin
            rx_state <= RX_IDLE;
        end else begin
            case (rx_state)
                RX_IDLE:  if (rx_fall) rx_state <= RX_START;
                RX_START: if (rx_tick) begin
                    rx_cnt   <= '0;
                    rx_state <= rx_bit ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_tick) begin
                    rx_shift <= {rx_bit, rx_shift[7:1]};
                    rx_cnt   <= rx_cnt + 1'b1;
                    if (rx_cnt == 3'd7) rx_state <= RX_STOP;
                end
                RX_STOP: if (rx_tick) begin
                    if (rx_bit) begin
                        rx_byte <= rx_shift;
                        rx_err  <= 1'b0;
                    end else begin
                        rx_err  <= 1'b1;
                    end
                    rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n)     hex_q <= {6{SEG_BLANK}};
        else if (SW[0]) hex_q <= baud_hex(baud_sel_t'(SW[2:1]));
        else            hex_q <= {6{SEG_BLANK}};
    end

    assign {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} = hex_q;
    assign LEDR           = {rx_err, tx_busy, rx_byte};
    assign GPIO_0[0]      = tx_line;
    assign GPIO_0[35:1]   = {35{1'bz}};
    assign unused_inputs  = ^{KEY[3:1], GPIO_0[35:2]};

endmodule

// File: tb/tb_top_uart_golden_top.sv
module tb_top_uart_golden_top;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  key;
    logic [9:0]  sw;
    logic [9:0]  ledr;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    wire  [35:0] gpio;
    logic        rx_drv;
    int          checks = 0;
    int          failures = 0;

    assign gpio[1] = rx_drv;
    always #10 clk = ~clk;

    top_uart_golden_top #(.CLK_FREQ_HZ(50000000)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key), .SW(sw), .LEDR(ledr),
        .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5),
        .GPIO_0(gpio)
    );

    initial begin
        #(150000 * 20);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wait_tx_start(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (gpio[0] === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Follows one TX frame bit by bit: first and last cycle of every bit.
    task automatic run_frame(input string name, input logic [7:0] data, input int unsigned div);
        bit   found;
        logic exp;
        wait_tx_start(found);
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s start: line stayed %b, required 0 within 20 cycles", name, gpio[0]);
            return;
        end
        for (int i = 0; i < 10; i++) begin
            exp = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : data[i-1];
            checks += 3;
            if (gpio[0] !== exp) begin
                failures++;
                $display("FAIL %s bit%0d first cycle: got %b required %b", name, i, gpio[0], exp);
            end
            if (ledr[8] !== 1'b1) begin
                failures++;
                $display("FAIL %s busy bit%0d: got %b required 1", name, i, ledr[8]);
            end
            repeat (div - 1) @(posedge clk);
            #1;
            if (gpio[0] !== exp) begin
                failures++;
                $display("FAIL %s bit%0d last cycle: got %b required %b", name, i, gpio[0], exp);
            end
            @(posedge clk); #1;
        end
        checks += 2;
        if (gpio[0] !== 1'b1) begin
            failures++;
            $display("FAIL %s idle line after stop: got %b required 1", name, gpio[0]);
        end
        if (ledr[8] !== 1'b0) begin
            failures++;
            $display("FAIL %s busy after stop: got %b required 0", name, ledr[8]);
        end
    endtask

    task automatic send_rx(input logic [7:0] data, input logic stop, input int unsigned div);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = data[i];
            repeat (div) @(negedge clk);
        end
        rx_drv = stop;
        repeat (div) @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key = '0; sw = '0; rx_drv = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        for (int pass = 0; pass < 2; pass++) begin
            checks += 3;
            if (gpio[0] !== 1'b1) begin
                failures++;
                $display("FAIL reset%0d tx line: got %b required 1", pass, gpio[0]);
            end
            if (ledr !== 10'h000) begin
                failures++;
                $display("FAIL reset%0d ledr: got %h required 000", pass, ledr);
            end
            if ({hex5, hex4, hex3, hex2, hex1, hex0} !== {6{7'h7F}}) begin
                failures++;
                $display("FAIL reset%0d hex: got %h required all 7F", pass,
                         {hex5, hex4, hex3, hex2, hex1, hex0});
            end
            @(negedge clk) rst_n = 1'b1;
            repeat (5) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_display();
        logic [9:0]  sw_tab  [5];
        logic [41:0] hex_tab [5];
        sw_tab[0] = 10'b0000000011; hex_tab[0] = {7'h7F, 7'h7F, 7'h10, 7'h02, 7'h40, 7'h40};
        sw_tab[1] = 10'b0000000111; hex_tab[1] = {7'h79, 7'h79, 7'h12, 7'h24, 7'h40, 7'h40};
        sw_tab[2] = 10'b0000000001; hex_tab[2] = {7'h7F, 7'h7F, 7'h19, 7'h00, 7'h40, 7'h40};
        sw_tab[3] = 10'b0000000101; hex_tab[3] = {7'h7F, 7'h79, 7'h10, 7'h24, 7'h40, 7'h40};
        sw_tab[4] = 10'b0000000110; hex_tab[4] = {6{7'h7F}};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) sw = sw_tab[i];
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if ({hex5, hex4, hex3, hex2, hex1, hex0} !== hex_tab[i]) begin
                failures++;
                $display("FAIL display sw=%b: got %h required %h", sw_tab[i],
                         {hex5, hex4, hex3, hex2, hex1, hex0}, hex_tab[i]);
            end
        end
    endtask

    task automatic test_tx_disabled();
        int lows, busies;
        logic [9:0] sw_tab [2];
        int         len    [2];
        sw_tab[0] = 10'b0000000001; len[0] = 500;    // enabled, TX off
        sw_tab[1] = 10'b0000010000; len[1] = 20000;  // TX on, UART disabled
        for (int t = 0; t < 2; t++) begin
            @(negedge clk) sw = sw_tab[t];
            repeat (3) @(negedge clk);
            key[0] = 1'b1;
            lows = 0; busies = 0;
            for (int c = 0; c < len[t]; c++) begin
                @(posedge clk); #1;
                if (gpio[0] !== 1'b1) lows++;
                if (ledr[8] !== 1'b0) busies++;
            end
            @(negedge clk) key[0] = 1'b0;
            checks += 2;
            if (lows != 0) begin
                failures++;
                $display("FAIL disabled%0d line: got %0d non-high cycles required 0", t, lows);
            end
            if (busies != 0) begin
                failures++;
                $display("FAIL disabled%0d busy: got %0d busy cycles required 0", t, busies);
            end
        end
    endtask

    task automatic test_tx_9600();
        @(negedge clk) sw = 10'b0000010011;
        repeat (4) @(negedge clk);
        key[0] = 1'b1;
        run_frame("tx9600", 8'h00, 5208);
        @(negedge clk) key[0] = 1'b0;
    endtask

    // Second press lands mid-frame; it must be dropped, not replayed later.
    task automatic test_tx_115200();
        int lows;
        @(negedge clk) sw = 10'b1010110111;
        repeat (4) @(negedge clk);
        key[0] = 1'b1;
        fork
            run_frame("tx115200", 8'h15, 434);
            begin
                repeat (300) @(negedge clk);
                key[0] = 1'b0;
                repeat (300) @(negedge clk);
                key[0] = 1'b1;
            end
        join
        lows = 0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (gpio[0] !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin
            failures++;
            $display("FAIL no_queue line: got %0d low cycles after frame required 0", lows);
        end
        @(negedge clk) key[0] = 1'b0;
    endtask

    task automatic test_abort();
        bit found;
        int lows;
        @(negedge clk) sw = 10'b1010110111;
        repeat (4) @(negedge clk);
        key[0] = 1'b1;
        wait_tx_start(found);
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL abort start: line got %b required 0 within 20 cycles", gpio[0]);
        end
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if (gpio[0] !== 1'b0) begin
            failures++;
            $display("FAIL abort pre line: got %b required 0", gpio[0]);
        end
        @(negedge clk) sw[4] = 1'b0;
        @(posedge clk); #1;
        checks += 2;
        if (gpio[0] !== 1'b1) begin
            failures++;
            $display("FAIL abort line: got %b required 1", gpio[0]);
        end
        if (ledr[8] !== 1'b0) begin
            failures++;
            $display("FAIL abort busy: got %b required 0", ledr[8]);
        end
        lows = 0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #1;
            if (gpio[0] !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin
            failures++;
            $display("FAIL abort hold: got %0d low cycles required 0", lows);
        end
        @(negedge clk) key[0] = 1'b0;
        sw[4] = 1'b1;
    endtask

    task automatic test_rx();
        @(negedge clk) sw = 10'b0000001111;
        repeat (5) @(negedge clk);
        send_rx(8'hA5, 1'b1, 434);
        checks += 2;
        if (ledr[7:0] !== 8'hA5) begin
            failures++;
            $display("FAIL rx_good byte: got %h required a5", ledr[7:0]);
        end
        if (ledr[9] !== 1'b0) begin
            failures++;
            $display("FAIL rx_good err: got %b required 0", ledr[9]);
        end
        send_rx(8'h3C, 1'b0, 434);
        checks += 2;
        if (ledr[9] !== 1'b1) begin
            failures++;
            $display("FAIL rx_ferr err: got %b required 1", ledr[9]);
        end
        if (ledr[7:0] !== 8'hA5) begin
            failures++;
            $display("FAIL rx_ferr byte: got %h required a5", ledr[7:0]);
        end
        // Low pulse shorter than half a bit: start bit samples high.
        @(negedge clk) rx_drv = 1'b0;
        repeat (50) @(negedge clk);
        rx_drv = 1'b1;
        repeat (1000) @(negedge clk);
        checks++;
        if (ledr[9:0] !== {1'b1, 1'b0, 8'hA5}) begin
            failures++;
            $display("FAIL rx_glitch ledr: got %h required 2a5", ledr);
        end
    endtask

    initial begin
        test_reset();
        test_display();
        test_tx_disabled();
        test_tx_9600();
        test_tx_115200();
        test_abort();
        test_rx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
